// File: rtl/signed_divider_seq.sv
// Iterative restoring divider: one quotient bit per clock, signed or unsigned per operation.
// Magnitudes are divided unsigned; signs are reapplied in a single fixup cycle.
module signed_divider_seq #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic         overflow,
    output logic [1:0]   dbg_state
);
    // Handshake: start is a one-cycle request honoured only while busy=0; the result
    // is valid exactly in the single cycle done=1 and is held until the next result.

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DIVIDE = 2'd1;
    localparam logic [1:0] FIXUP  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

    logic [1:0]    state;
    logic [N:0]    p;
    logic [N-1:0]  q;
    logic [N-1:0]  dmag;
    logic [CW-1:0] cnt;
    logic          q_neg;
    logic          r_neg;
    logic          ovf_pend;

    logic          dd_neg;
    logic          dv_neg;
    logic [N-1:0]  dd_mag;
    logic [N-1:0]  dv_mag;
    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic [N-1:0]  fix_q;
    logic [N-1:0]  fix_r;

    assign dd_neg = signed_mode & dividend[N-1];
    assign dv_neg = signed_mode & divisor[N-1];
    // The most negative value maps to itself, which reads correctly as an unsigned magnitude.
    assign dd_mag = dd_neg ? (~dividend + N'(1)) : dividend;
    assign dv_mag = dv_neg ? (~divisor + N'(1)) : divisor;

    assign shifted = {p[N-1:0], q[N-1]};
    assign trial   = shifted - {1'b0, dmag};

    assign fix_q = q_neg ? (~q + N'(1)) : q;
    assign fix_r = r_neg ? (~p[N-1:0] + N'(1)) : p[N-1:0];

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            p           <= '0;
            q           <= '0;
            dmag        <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            p        <= '0;
                            q        <= dd_mag;
                            dmag     <= dv_mag;
                            q_neg    <= dd_neg ^ dv_neg;
                            r_neg    <= dd_neg;
                            ovf_pend <= signed_mode && (dividend == MOST_NEG) && (divisor == '1);
                            cnt      <= '0;
                            state    <= DIVIDE;
                        end
                    end
                end
                DIVIDE: begin
                    // Non-negative trial difference means the divisor fits: keep it, quotient bit 1.
                    if (!trial[N]) begin
                        p <= trial;
                        q <= {q[N-2:0], 1'b1};
                    end else begin
                        p <= shifted;
                        q <= {q[N-2:0], 1'b0};
                    end
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) state <= FIXUP;
                end
                FIXUP: begin
                    // Outputs load on this edge so they become visible together with done.
                    quotient    <= fix_q;
                    remainder   <= fix_r;
                    overflow    <= ovf_pend;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider_seq.sv
// Bench for signed_divider_seq: directed cases from the arithmetic rules, then randomized
// traffic, all compared every cycle against an integer-arithmetic reference with timing model.
module tb_signed_divider_seq;
    localparam int N = 4;
    localparam int W = 2 * N + 2;  // {quotient, remainder, div_by_zero, overflow}
    localparam int T = W + 2;      // {busy, done, result}

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic         overflow;
    logic [1:0]   dbg_state;

    signed_divider_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .dividend(dividend), .divisor(divisor), .quotient(quotient),
        .remainder(remainder), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .overflow(overflow), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_res = '0;
    int busy_start = -1;
    int busy_end = -1;
    int done_cyc = -1;
    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [T-1:0] got, input logic [T-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s cycle %0d: got busy/done/q/r/dz/ov=%b required %b", name, cyc, got, exp);
        end
    endtask

    // Reference: plain integer division (C semantics truncate toward zero).
    function automatic logic [W-1:0] ref_div(input logic sm, input logic [N-1:0] dd,
                                             input logic [N-1:0] dv);
        int a;
        int b;
        logic [N-1:0] qq;
        logic [N-1:0] rr;
        logic ov;
        if (dv == '0) return {{N{1'b1}}, dd, 1'b1, 1'b0};
        if (sm) begin
            a = int'($signed(dd));
            b = int'($signed(dv));
        end else begin
            a = int'(dd);
            b = int'(dv);
        end
        qq = N'(a / b);
        rr = N'(a % b);
        ov = sm && (a == -(1 << (N - 1))) && (b == -1);
        return {qq, rr, 1'b0, ov};
    endfunction

    // ---------------- compare process ----------------
    initial begin
        logic exp_busy;
        logic exp_done;
        forever begin
            @(negedge clk);
            if (cyc == done_cyc) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL queue cycle %0d: got empty expected queue required one entry", cyc);
                end else begin
                    cur_res = exp_q.pop_front();
                end
            end
            exp_done = (cyc == done_cyc);
            exp_busy = (cyc >= busy_start) && (cyc <= busy_end);
            check("outputs", {busy, done, quotient, remainder, div_by_zero, overflow},
                  {exp_busy, exp_done, cur_res});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic sm, input logic [N-1:0] dd, input logic [N-1:0] dv);
        @(posedge clk);
        #2;
        start = 1'b1;
        signed_mode = sm;
        dividend = dd;
        divisor = dv;
        if (!rst && cyc > busy_end) begin
            exp_q.push_back(ref_div(sm, dd, dv));
            busy_start = cyc + 1;
            done_cyc = (dv == '0) ? cyc + 1 : cyc + N + 2;
            busy_end = done_cyc;
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        signed_mode = 1'($urandom);
        dividend = N'($urandom);
        divisor = N'($urandom);
    endtask

    // Called just after a rising edge; drops all in-flight expectations.
    task automatic do_reset();
        rst = 1'b1;
        cur_res = '0;
        exp_q.delete();
        busy_start = -1;
        busy_end = -1;
        done_cyc = -1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100 && cyc <= busy_end; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Literal check in the done cycle, `cycles` edges after issue() returns.
    task automatic expect_done(input int cycles, input logic [W-1:0] exp);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check("plan", {busy, done, quotient, remainder, div_by_zero, overflow}, {2'b11, exp});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic sm;
        logic [N-1:0] dd;
        logic [N-1:0] dv;

        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        check("model_a", {2'b00, ref_div(1'b1, 4'b1001, 4'b1101)}, {2'b00, 4'b0010, 4'b1111, 2'b00});
        check("model_b", {2'b00, ref_div(1'b1, 4'b0111, 4'b1110)}, {2'b00, 4'b1101, 4'b0001, 2'b00});
        check("model_c", {2'b00, ref_div(1'b1, 4'b1000, 4'b1111)}, {2'b00, 4'b1000, 4'b0000, 2'b01});

        issue(1'b1, 4'b1001, 4'b1101);
        expect_done(N + 1, {4'b0010, 4'b1111, 2'b00});
        issue(1'b0, 4'b1001, 4'b1101);
        expect_done(N + 1, {4'b0000, 4'b1001, 2'b00});
        issue(1'b1, 4'b0111, 4'b1110);
        expect_done(N + 1, {4'b1101, 4'b0001, 2'b00});
        issue(1'b1, 4'b1000, 4'b1111);
        expect_done(N + 1, {4'b1000, 4'b0000, 2'b01});
        issue(1'b1, 4'b0110, 4'b0010);
        expect_done(N + 1, {4'b0011, 4'b0000, 2'b00});
        issue(1'b1, 4'b0101, 4'b0000);
        expect_done(0, {4'b1111, 4'b0101, 2'b10});

        // A start landing two cycles into a divide must be ignored.
        issue(1'b1, 4'b1001, 4'b1101);
        issue(1'b0, 4'b0011, 4'b0001);
        expect_done(N - 1, {4'b0010, 4'b1111, 2'b00});

        // Reset three cycles into a divide aborts it; the next operation runs normally.
        issue(1'b1, 4'b0111, 4'b1110);
        repeat (2) @(posedge clk);
        #2;
        do_reset();
        issue(1'b1, 4'b0111, 4'b1110);
        expect_done(N + 1, {4'b1101, 4'b0001, 2'b00});

        for (int i = 0; i < 400; i++) begin
            sm = 1'($urandom);
            dd = N'($urandom);
            dv = N'($urandom);
            case ($urandom_range(0, 9))
                0: dv = '0;
                1: begin
                    sm = 1'b1;
                    dd = {1'b1, {(N-1){1'b0}}};
                    dv = '1;
                end
                default: ;
            endcase
            repeat ($urandom_range(0, N + 4)) @(posedge clk);
            issue(sm, dd, dv);
            if ($urandom_range(0, 59) == 0) begin
                repeat ($urandom_range(0, N)) @(posedge clk);
                #2;
                do_reset();
            end
        end

        wait_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
